// File: rtl/sec_digit_counter.sv
// Two-digit 00..59 seconds counter with run/pause control, advanced by a prescaled tick.
// Digits, tick and wrap are all registered; they change on the edge that commits the count.
module sec_digit_counter #(
    parameter int TICK_DIV = 100000000,
    parameter int ONES_LIM = 9,
    parameter int TENS_LIM = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start_stop,
    input  logic       clear,
    input  logic       load,
    input  logic [3:0] load_ones,
    input  logic [3:0] load_tens,
    output logic [3:0] ones,
    output logic [3:0] tens,
    output logic       running,
    output logic       tick,
    output logic       wrap
);
    localparam int PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);
    localparam logic [3:0] OL = 4'(ONES_LIM);
    localparam logic [3:0] TL = 4'(TENS_LIM);

    typedef enum logic [1:0] {IDLE, RUN, PAUSED} state_t;

    state_t        state, state_nxt;
    logic [PW-1:0] presc;
    logic          tick_int;
    logic [4:0]    ones_inc, tens_inc;

    // Returns {carry, digit}; anything past the limit (including out-of-range inputs) clears with carry.
    function automatic logic [4:0] inc(input logic [3:0] x, input logic ci, input logic [3:0] lim);
        logic [4:0] s;
        s = {1'b0, x} + {4'b0, ci};
        if (s > {1'b0, lim})
            return 5'b1_0000;
        return s;
    endfunction

    always_comb begin
        tick_int = (state == RUN) && (presc == PMAX);
        ones_inc = inc(ones, 1'b1, OL);
        tens_inc = inc(tens, ones_inc[4], TL);
        state_nxt = state;
        if (clear)
            state_nxt = IDLE;
        else if (start_stop) begin
            case (state)
                IDLE:    state_nxt = RUN;
                RUN:     state_nxt = PAUSED;
                PAUSED:  state_nxt = RUN;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            presc   <= '0;
            ones    <= '0;
            tens    <= '0;
            running <= 1'b0;
            tick    <= 1'b0;
            wrap    <= 1'b0;
        end else begin
            state   <= state_nxt;
            running <= (state_nxt == RUN);
            tick    <= 1'b0;
            wrap    <= 1'b0;
            if (clear) begin
                presc <= '0;
                ones  <= '0;
                tens  <= '0;
            end else begin
                // The tick commits even when start_stop pauses on the same edge.
                if (tick_int) begin
                    ones <= ones_inc[3:0];
                    tens <= tens_inc[3:0];
                    tick <= 1'b1;
                    wrap <= ones_inc[4] & tens_inc[4];
                end
                case (state)
                    RUN:     presc <= tick_int ? '0 : presc + 1'b1;
                    IDLE:    presc <= '0;
                    default: presc <= presc;
                endcase
                if (!start_stop && load && state != RUN) begin
                    ones <= load_ones;
                    tens <= load_tens;
                end
            end
        end
    end
endmodule

// File: tb/tb_sec_digit_counter.sv
// Randomized and directed checks of sec_digit_counter against a cycle-level behavioural model.
module tb_sec_digit_counter;
    localparam int TD = 4;
    localparam int OL = 9;
    localparam int TL = 5;

    logic       clk = 1'b0;
    logic       reset = 1'b0, start_stop = 1'b0, clear = 1'b0, load = 1'b0;
    logic [3:0] load_ones = '0, load_tens = '0;
    logic [3:0] ones, tens;
    logic       running, tick, wrap;

    sec_digit_counter #(.TICK_DIV(TD), .ONES_LIM(OL), .TENS_LIM(TL)) dut (
        .clk(clk), .reset(reset), .start_stop(start_stop), .clear(clear), .load(load),
        .load_ones(load_ones), .load_tens(load_tens),
        .ones(ones), .tens(tens), .running(running), .tick(tick), .wrap(wrap)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Model: mode 0 idle, 1 running, 2 paused; elapsed = cycles into current tick period.
    int m_mode = 0, m_elapsed = 0, m_ones = 0, m_tens = 0, m_tick = 0, m_wrap = 0;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int bump(input int x, input int ci, input int lim, output int co);
        int s;
        s = x + ci;
        co = (s > lim) ? 1 : 0;
        return co ? 0 : s;
    endfunction

    task automatic model_edge(input bit r, input bit ss, input bit cl, input bit ld,
                              input int lo, input int lt);
        int co1, co2, no, nt;
        m_tick = 0;
        m_wrap = 0;
        if (r) begin
            m_mode = 0; m_elapsed = 0; m_ones = 0; m_tens = 0;
        end else if (cl) begin
            m_mode = 0; m_elapsed = 0; m_ones = 0; m_tens = 0;
        end else begin
            if (m_mode == 1) begin
                if (m_elapsed == TD - 1) begin
                    no = bump(m_ones, 1, OL, co1);
                    nt = bump(m_tens, co1, TL, co2);
                    m_ones = no; m_tens = nt;
                    m_tick = 1; m_wrap = co1 & co2;
                end
                m_elapsed = (m_elapsed + 1) % TD;
            end
            if (ss)
                m_mode = (m_mode == 1) ? 2 : 1;
            else if (ld && m_mode != 1) begin
                m_ones = lo; m_tens = lt;
            end
        end
    endtask

    task automatic step(input bit r = 0, input bit ss = 0, input bit cl = 0, input bit ld = 0,
                        input int lo = 0, input int lt = 0);
        reset = r; start_stop = ss; clear = cl; load = ld;
        load_ones = 4'(lo); load_tens = 4'(lt);
        @(posedge clk);
        model_edge(r, ss, cl, ld, lo, lt);
        #1;
        reset = 0; start_stop = 0; clear = 0; load = 0;
        check("ones", ones, m_ones);
        check("tens", tens, m_tens);
        check("running", running, (m_mode == 1) ? 1 : 0);
        check("tick", tick, m_tick);
        check("wrap", wrap, m_wrap);
    endtask

    initial begin
        int nt, wraps;
        // Reset state
        step(.r(1));
        check("rst_ones", ones, 0);
        check("rst_running", running, 0);
        check("rst_tick", tick, 0);

        // Free run: ten ticks, tens rolls to 1, no wrap
        step(.ss(1));
        check("run_rises", running, 1);
        nt = 0; wraps = 0;
        for (int i = 0; i < 10 * TD; i++) begin
            step();
            nt += tick; wraps += wrap;
        end
        check("ten_ticks", nt, 10);
        check("no_wrap", wraps, 0);
        check("tens_roll", tens, 1);
        check("ones_roll", ones, 0);

        // 59 -> 00 wraps once
        step(.cl(1));
        step(.ld(1), .lo(9), .lt(5));
        step(.ss(1));
        for (int i = 0; i < TD - 1; i++) step();
        check("pre_wrap_tick", tick, 0);
        step();
        check("wrap_pulse", wrap, 1);
        check("wrap_tick", tick, 1);
        check("wrap_digits", {tens, ones}, 0);
        step();
        check("wrap_one_cycle", wrap, 0);

        // Out-of-range ones digit
        step(.cl(1));
        step(.ld(1), .lo(12), .lt(3));
        step(.ss(1));
        for (int i = 0; i < TD; i++) step();
        check("oor_ones", ones, 0);
        check("oor_ones_tens", tens, 4);
        // Out-of-range tens digit
        step(.cl(1));
        step(.ld(1), .lo(2), .lt(7));
        step(.ss(1));
        for (int i = 0; i < TD; i++) step();
        check("oor_tens_ones", ones, 3);
        check("oor_tens", tens, 0);

        // Pause keeps the partial period
        step(.cl(1));
        step(.ss(1));
        step();
        step(.ss(1));
        check("paused", running, 0);
        nt = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            nt += tick;
        end
        check("pause_no_tick", nt, 0);
        check("pause_frozen", ones, 0);
        step(.ss(1));
        step();
        check("resume_early", tick, 0);
        step();
        check("resume_tick", tick, 1);
        check("resume_ones", ones, 1);

        // Clear beats start_stop
        step(.cl(1));
        step(.ld(1), .lo(6), .lt(0));
        step(.ss(1));
        for (int i = 0; i < TD; i++) step();
        check("pre_clear_ones", ones, 7);
        step(.cl(1), .ss(1));
        check("clear_running", running, 0);
        check("clear_ones", ones, 0);
        nt = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            nt += tick;
        end
        check("clear_no_tick", nt, 0);

        // Load ignored while running; reset mid-count
        step(.ld(1), .lo(3), .lt(3));
        step(.ss(1));
        for (int i = 0; i < TD; i++) step();
        step(.ld(1), .lo(9), .lt(9));
        check("load_in_run", {tens, ones}, 8'h34);
        step();
        step(.r(1));
        check("reset_digits", {tens, ones}, 0);
        check("reset_running", running, 0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            step(.r($urandom_range(0, 199) == 0),
                 .ss($urandom_range(0, 15) == 0),
                 .cl($urandom_range(0, 63) == 0),
                 .ld($urandom_range(0, 7) == 0),
                 .lo(int'($urandom_range(0, 15))),
                 .lt(int'($urandom_range(0, 15))));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
